// File: rtl/gc_cmd_sequencer.sv
// Command sequencer for the GameCube controller one-wire slave: snapshot, frame build, CMD_DONE.
// Define GC_CAL_CMD_EN to decode 0x42 as calibrate (origin := current sticks/triggers).
module gc_cmd_sequencer #(
   parameter int unsigned TX_BUFFER_WIDTH = 80,
   parameter logic [23:0] DEVICE_ID       = 24'h090000,
   parameter logic [7:0]  RESP_DELAY      = 8'd40,
   parameter logic [2:0]  DONE_CYCLES     = 3'd4
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [23:0]                COMMAND,
   input  logic                       NEW_COMMAND,
   input  logic [15:0]                BUTTONS,
   input  logic [7:0]                 JOY_X,
   input  logic [7:0]                 JOY_Y,
   input  logic [7:0]                 CSTICK_X,
   input  logic [7:0]                 CSTICK_Y,
   input  logic [7:0]                 TRIG_L,
   input  logic [7:0]                 TRIG_R,
   output logic [TX_BUFFER_WIDTH-1:0] TX_BUFFER,
   output logic [7:0]                 TX_BIT_TOTAL,
   output logic                       CMD_DONE,
   output logic                       CONTROLLER_RESET,
   output logic [1:0]                 RUMBLE,
   output logic                       BUSY,
   output logic [7:0]                 LAST_CMD
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLatch = 3'd1;
   localparam logic [2:0] StBuild = 3'd2;
   localparam logic [2:0] StWait  = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;
   localparam logic [2:0] StAbort = 3'd5;

   localparam logic [7:0] CmdIdentify = 8'h00;
   localparam logic [7:0] CmdReset    = 8'hFF;
   localparam logic [7:0] CmdPoll     = 8'h40;
   localparam logic [7:0] CmdOrigin   = 8'h41;
`ifdef GC_CAL_CMD_EN
   localparam logic [7:0] CmdCal      = 8'h42;
`endif
   localparam logic [7:0] PollMode    = 8'h03;

   // Origin packed as {jx, jy, cx, cy, L, R}.
   localparam logic [47:0] OriginReset = 48'h8080_8080_0000;

   logic [2:0]  state;
   logic [7:0]  snap_op;
   logic [7:0]  snap_mode;
   logic [1:0]  snap_rumble;
   logic [15:0] snap_buttons;
   logic [47:0] snap_analog;
   logic [47:0] origin;
   logic        need_origin;
   logic [7:0]  wait_cnt;
   logic [2:0]  done_cnt;

   logic                       cmd_ok;
   logic [15:0]                buttons_resp;
   logic [47:0]                origin_next;
   logic [79:0]                frame;
   logic [7:0]                 total_next;
   logic [TX_BUFFER_WIDTH-1:0] tx_next;

   // Only the command byte, poll mode and rumble bits are ever consulted.
   logic unused_cmd;
   assign unused_cmd = ^COMMAND[7:2];

   assign BUSY = (state != StIdle);

   always_comb begin
      cmd_ok = 1'b0;
      case (snap_op)
         CmdIdentify, CmdReset, CmdOrigin: cmd_ok = 1'b1;
         CmdPoll:                          cmd_ok = (snap_mode == PollMode);
`ifdef GC_CAL_CMD_EN
         CmdCal:                           cmd_ok = 1'b1;
`endif
         default:                          cmd_ok = 1'b0;
      endcase
   end

   always_comb begin
      buttons_resp     = snap_buttons;
      buttons_resp[7]  = 1'b1;
      buttons_resp[13] = need_origin;

      origin_next = origin;
`ifdef GC_CAL_CMD_EN
      if (snap_op == CmdCal) begin
         origin_next = snap_analog;
      end
`endif

      // Only consulted in BUILD after LATCH has validated the command.
      case (snap_op)
         CmdPoll: begin
            frame      = {buttons_resp, snap_analog, 16'h0000};
            total_next = 8'd64;
         end
`ifdef GC_CAL_CMD_EN
         CmdOrigin, CmdCal: begin
`else
         CmdOrigin: begin
`endif
            frame      = {buttons_resp, origin_next, 16'h0000};
            total_next = 8'd80;
         end
         default: begin
            frame      = {DEVICE_ID, 56'h0};
            total_next = 8'd24;
         end
      endcase

      tx_next                            = '0;
      tx_next[TX_BUFFER_WIDTH-1 -: 80]   = frame;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state            <= StIdle;
         snap_op          <= 8'h00;
         snap_mode        <= 8'h00;
         snap_rumble      <= 2'b00;
         snap_buttons     <= 16'h0000;
         snap_analog      <= 48'h0;
         origin           <= OriginReset;
         need_origin      <= 1'b1;
         wait_cnt         <= 8'd0;
         done_cnt         <= 3'd0;
         TX_BUFFER        <= '0;
         TX_BIT_TOTAL     <= 8'd0;
         CMD_DONE         <= 1'b0;
         CONTROLLER_RESET <= 1'b0;
         RUMBLE           <= 2'b00;
         LAST_CMD         <= 8'h00;
      end else begin
         case (state)
            StIdle: begin
               if (NEW_COMMAND) begin
                  snap_op      <= COMMAND[23:16];
                  snap_mode    <= COMMAND[15:8];
                  snap_rumble  <= COMMAND[1:0];
                  snap_buttons <= BUTTONS;
                  snap_analog  <= {JOY_X, JOY_Y, CSTICK_X, CSTICK_Y, TRIG_L, TRIG_R};
                  state        <= StLatch;
               end
            end
            StLatch: begin
               if (cmd_ok) begin
                  state <= StBuild;
               end else begin
                  CONTROLLER_RESET <= 1'b1;
                  state            <= StAbort;
               end
            end
            StBuild: begin
               TX_BUFFER    <= tx_next;
               TX_BIT_TOTAL <= total_next;
               LAST_CMD     <= snap_op;
               origin       <= origin_next;
               wait_cnt     <= RESP_DELAY;
               case (snap_op)
                  CmdReset: begin
                     RUMBLE      <= 2'b00;
                     need_origin <= 1'b1;
                  end
                  CmdPoll: RUMBLE <= snap_rumble;
`ifdef GC_CAL_CMD_EN
                  CmdOrigin, CmdCal: need_origin <= 1'b0;
`else
                  CmdOrigin: need_origin <= 1'b0;
`endif
                  default: ;
               endcase
               state <= StWait;
            end
            StWait: begin
               // Counter would hit 0 on this decrement: raise CMD_DONE now.
               if (wait_cnt <= 8'd1) begin
                  CMD_DONE <= 1'b1;
                  done_cnt <= DONE_CYCLES;
                  state    <= StDone;
               end else begin
                  wait_cnt <= wait_cnt - 8'd1;
               end
            end
            StDone: begin
               if (done_cnt <= 3'd1) begin
                  CMD_DONE <= 1'b0;
                  state    <= StIdle;
               end else begin
                  done_cnt <= done_cnt - 3'd1;
               end
            end
            StAbort: begin
               CONTROLLER_RESET <= 1'b0;
               state            <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/gc_cmd_sequencer.md
# gc_cmd_sequencer

Command sequencer for the GameCube controller one-wire slave. Consumes each decoded COMMAND/NEW_COMMAND from the one-wire interface, snapshots the controller input state, builds the response frame and bit count, then releases the interface with a timed CMD_DONE pulse. Unsupported commands abort via CONTROLLER_RESET so the interface never stalls waiting for CMD_DONE. Sits between the one-wire interface and the button/ADC sampling logic in the controller top.

## Interface
- TX_BUFFER_WIDTH, 80: response buffer width. Must match the interface. Minimum 80.
- DEVICE_ID, 24'h090000: identify/reset response.
- RESP_DELAY, 8'd40: cycles from frame build to CMD_DONE rise, about 1 us at 40 MHz. Minimum 1.
- DONE_CYCLES, 3'd4: CMD_DONE high time in cycles. Minimum 1.
- CLK  in  1  40 MHz clock.
- RESET  in  1  asynchronous, active-high reset. The interface's RESET is active-low, so the top inverts it.
- COMMAND  in  24  received command; [23:16] is the command byte.
- NEW_COMMAND  in  1  one-cycle strobe, COMMAND valid.
- BUTTONS  in  16  live buttons, poll byte0/byte1 layout.
- JOY_X, JOY_Y, CSTICK_X, CSTICK_Y, TRIG_L, TRIG_R  in  8 each  live analog values.
- TX_BUFFER  out  TX_BUFFER_WIDTH  response, MSB-first, left-aligned, unused LSBs 0.
- TX_BIT_TOTAL  out  8  response length in bits.
- CMD_DONE  out  1  release pulse to the interface.
- CONTROLLER_RESET  out  1  one-cycle abort to the interface.
- RUMBLE  out  2  latched rumble bits from the last poll.
- BUSY  out  1  high in every state except IDLE.
- LAST_CMD  out  8  last accepted command byte.

## Operation
- Reset values:
  - TX_BUFFER=0, TX_BIT_TOTAL=0, CMD_DONE=0, CONTROLLER_RESET=0, RUMBLE=0, BUSY=0, LAST_CMD=0.
  - Origin registers: sticks 8'h80, triggers 8'h00.
  - need_origin=1.
- States: IDLE, LATCH, BUILD, WAIT, DONE, ABORT.
- IDLE: on NEW_COMMAND, register COMMAND and all inputs into a snapshot, then go to LATCH.
- LATCH: decode COMMAND[23:16]. 0x00, 0xFF, 0x40, 0x41 (and 0x42 when enabled) go to BUILD; anything else goes to ABORT.
  - For byte-only commands, COMMAND[15:0] is stale and must be ignored.
- BUILD: write TX_BUFFER and TX_BIT_TOTAL, update LAST_CMD, load the wait counter with RESP_DELAY, go to WAIT.
  - 0x00 identify: {DEVICE_ID, 56'h0}, total 24.
  - 0xFF reset: same frame as identify; also RUMBLE<=0 and need_origin<=1.
  - 0x40 poll: accepted only when COMMAND[15:8]==8'h03; other modes go to ABORT.
    - RUMBLE<=COMMAND[1:0].
    - Frame: {buttons', jx, jy, cx, cy, L, R, 16'h0}, total 64.
    - buttons' = snapshot BUTTONS with bit7 forced to 1 and bit13 = need_origin.
  - 0x41 origin: {buttons', origin sticks/triggers, 16'h0000}, total 80; need_origin<=0.
  - 0x42 calibrate: copy snapshot sticks/triggers into the origin registers first, then respond as for 0x41.
- WAIT: decrement the counter; at 0, set CMD_DONE=1 and go to DONE.
- DONE: hold CMD_DONE for DONE_CYCLES cycles, then clear it and go to IDLE.
- ABORT: pulse CONTROLLER_RESET for 1 cycle, leave TX_BUFFER unchanged, go to IDLE.
- TX_BUFFER and TX_BIT_TOTAL stay stable from BUILD until the next BUILD, so they remain valid through the whole interface transmission.

## Timing
- NEW_COMMAND high in cycle N:
  - LATCH in N+1.
  - TX_BUFFER valid from N+3.
  - CMD_DONE rises at N+3+RESP_DELAY and is high for exactly DONE_CYCLES cycles.
- Abort: CONTROLLER_RESET high in cycle N+2 only.
- NEW_COMMAND while BUSY is ignored: no state change, snapshot not overwritten.
- NEW_COMMAND in the cycle DONE exits to IDLE is ignored. It is accepted one cycle later.
- RESET mid-sequence: all outputs take reset values immediately (asynchronous), including clearing CMD_DONE while it is high.
- Snapshot values are frozen at cycle N. Input changes after N do not affect the frame.

## Configuration
- GC_CAL_CMD_EN defined: 0x42 is decoded as calibrate, as described above.
- GC_CAL_CMD_EN undefined: 0x42 goes to ABORT, and the origin registers change only at reset.

## Test plan
- Identify: COMMAND=24'h00xxxx (stale low bits) -> TX_BUFFER[79:56]=24'h090000, TX_BIT_TOTAL=24, CMD_DONE high 4 cycles starting N+43.
- Poll: COMMAND=24'h400301, BUTTONS=16'h0100, JOY_X=8'h90, need_origin=1 -> TX_BUFFER[79:64]=16'h2180, TX_BIT_TOTAL=64, RUMBLE=2'b01.
- Origin, then poll: 0x41 -> TX_BIT_TOTAL=80, origin bytes 80 80 80 80 00 00. A following 0x400300 -> bit13 of byte0/1 = 0.
- Calibrate (GC_CAL_CMD_EN): JOY_X=8'h7A, then 0x42 -> origin byte2=8'h7A. A following 0x41 -> byte2 still 8'h7A.
- Unknown command 0x54 -> CONTROLLER_RESET=1 for exactly 1 cycle at N+2, no CMD_DONE, TX_BUFFER unchanged.
- RESET asserted during DONE -> CMD_DONE=0 and BUSY=0 asynchronously. A second NEW_COMMAND during WAIT -> ignored, LAST_CMD unchanged.
